spi_arbiter: RTL

//  Shares one spi_master between two requesters: A (accelerometer sequencer) and B (config/debug).

---
 rtl/spi_arbiter_pkg.sv | 18 +
 rtl/rr_pick2.sv | 28 ++
 rtl/spi_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the two-requester SPI arbiter.
// Used by spi_arbiter and rr_pick2.
package spi_arbiter_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int NBITS_W_DEF = 6;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way tie-break: a sole requester wins; on a tie the side not
// granted last wins, or A always wins when FIXED_PRIO is set.
module rr_pick2
  import spi_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = a_req | b_req;
    grant_id    = OWNER_A;
    unique case (1'b1)
      (a_req & b_req):
        grant_id = FIXED_PRIO ? OWNER_A : ~last_grant;
      (b_req & ~a_req):
        grant_id = OWNER_B;
      default:
        grant_id = OWNER_A;
    endcase
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master between requesters A and B, one transfer per grant.
// Optional transfer watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int NBITS_W        = NBITS_W_DEF,
  parameter bit FIXED_PRIO     = 1'b0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               CLK12M,
  input  logic               nrst,
  input  logic               a_req,
  input  logic [DATA_W-1:0]  a_wdata,
  input  logic [NBITS_W-1:0] a_nbits,
  output logic               a_ack,
  output logic               a_done,
  output logic [DATA_W-1:0]  a_rdata,
  input  logic               b_req,
  input  logic [DATA_W-1:0]  b_wdata,
  input  logic [NBITS_W-1:0] b_nbits,
  output logic               b_ack,
  output logic               b_done,
  output logic [DATA_W-1:0]  b_rdata,
  output logic               err,
  output logic               busy,
  output logic               owner,
  output logic               spi_request,
  output logic [DATA_W-1:0]  spi_mosi,
  output logic [NBITS_W-1:0] spi_nbits,
  input  logic [DATA_W-1:0]  spi_miso,
  input  logic               spi_ready
);

  state_t state;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_id;

  rr_pick2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          waiting;
  logic          finish_ok;

  assign waiting   = (state == ST_WAIT_BUSY) ||
                     (state == ST_WAIT_DONE);
  assign finish_ok = (state == ST_WAIT_DONE) && spi_ready;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLK12M or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      last_grant  <= OWNER_B;
      a_ack       <= 1'b0;
      a_done      <= 1'b0;
      a_rdata     <= '0;
      b_ack       <= 1'b0;
      b_done      <= 1'b0;
      b_rdata     <= '0;
      busy        <= 1'b0;
      owner       <= OWNER_A;
      spi_request <= 1'b0;
      spi_mosi    <= '0;
      spi_nbits   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err         <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      spi_request <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err         <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          // master must be idle before a new grant is made
          if (spi_ready && grant_valid) begin
            spi_mosi  <= grant_id ? b_wdata : a_wdata;
            spi_nbits <= grant_id ? b_nbits : a_nbits;
            owner     <= grant_id;
            busy      <= 1'b1;
            a_ack     <= (grant_id == OWNER_A);
            b_ack     <= (grant_id == OWNER_B);
            state     <= ST_ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          spi_request <= 1'b1;
          state       <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!spi_ready) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (spi_ready) begin
            if (owner == OWNER_B) begin
              b_rdata <= spi_miso;
              b_done  <= 1'b1;
            end else begin
              a_rdata <= spi_miso;
              a_done  <= 1'b1;
            end
            busy       <= 1'b0;
            last_grant <= owner;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef SPI_ARB_TIMEOUT_EN
      // a real completion in the same cycle takes precedence
      if (waiting && !finish_ok) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          a_done     <= (owner == OWNER_A);
          b_done     <= (owner == OWNER_B);
          err        <= 1'b1;
          busy       <= 1'b0;
          last_grant <= owner;
          state      <= ST_IDLE;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
